// File: rtl/vliw_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : vliw_writeback_if
// Description : Bundle of the writeback stage signals. Carries, for each of
//               the four execution slots (lsu, ixu1, ixu2, branch):
//                 <u>_res_valid/rd/data  slot result coming into writeback
//                 <u>_iss_valid/iss_rd   destination of an instruction issued
//                 <u>_wr_en/rd/wr_data   register file write port for slot u
//               plus flush, the busy scoreboard and the sticky collision_err.
//               master : the side driving results/issues (pipeline, bench)
//               slave  : the writeback stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface vliw_writeback_if #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = 5
);
    logic             flush;

    logic             lsu_res_valid,    ixu1_res_valid,    ixu2_res_valid,    branch_res_valid;
    logic [AW-1:0]    lsu_res_rd,       ixu1_res_rd,       ixu2_res_rd,       branch_res_rd;
    logic [XLEN-1:0]  lsu_res_data,     ixu1_res_data,     ixu2_res_data,     branch_res_data;

    logic             lsu_iss_valid,    ixu1_iss_valid,    ixu2_iss_valid,    branch_iss_valid;
    logic [AW-1:0]    lsu_iss_rd,       ixu1_iss_rd,       ixu2_iss_rd,       branch_iss_rd;

    logic             lsu_wr_en,        ixu1_wr_en,        ixu2_wr_en,        branch_wr_en;
    logic [AW-1:0]    lsu_rd,           ixu1_rd,           ixu2_rd,           branch_rd;
    logic [XLEN-1:0]  lsu_wr_data,      ixu1_wr_data,      ixu2_wr_data,      branch_wr_data;

    logic [NREGS-1:0] busy;
    logic             collision_err;

    modport master (
        output flush,
        output lsu_res_valid, ixu1_res_valid, ixu2_res_valid, branch_res_valid,
        output lsu_res_rd,    ixu1_res_rd,    ixu2_res_rd,    branch_res_rd,
        output lsu_res_data,  ixu1_res_data,  ixu2_res_data,  branch_res_data,
        output lsu_iss_valid, ixu1_iss_valid, ixu2_iss_valid, branch_iss_valid,
        output lsu_iss_rd,    ixu1_iss_rd,    ixu2_iss_rd,    branch_iss_rd,
        input  lsu_wr_en,     ixu1_wr_en,     ixu2_wr_en,     branch_wr_en,
        input  lsu_rd,        ixu1_rd,        ixu2_rd,        branch_rd,
        input  lsu_wr_data,   ixu1_wr_data,   ixu2_wr_data,   branch_wr_data,
        input  busy, collision_err
    );

    modport slave (
        input  flush,
        input  lsu_res_valid, ixu1_res_valid, ixu2_res_valid, branch_res_valid,
        input  lsu_res_rd,    ixu1_res_rd,    ixu2_res_rd,    branch_res_rd,
        input  lsu_res_data,  ixu1_res_data,  ixu2_res_data,  branch_res_data,
        input  lsu_iss_valid, ixu1_iss_valid, ixu2_iss_valid, branch_iss_valid,
        input  lsu_iss_rd,    ixu1_iss_rd,    ixu2_iss_rd,    branch_iss_rd,
        output lsu_wr_en,     ixu1_wr_en,     ixu2_wr_en,     branch_wr_en,
        output lsu_rd,        ixu1_rd,        ixu2_rd,        branch_rd,
        output lsu_wr_data,   ixu1_wr_data,   ixu2_wr_data,   branch_wr_data,
        output busy, collision_err
    );
endinterface
`default_nettype wire

// File: rtl/vliw_writeback.sv
`default_nettype none
// ============================================================================
// Module      : vliw_writeback
// Description : Writeback stage for the four-slot VLIW core. Registers each
//               slot result for one cycle and drives the 4-port register
//               file, drops writes to x0, resolves same-rd collisions by
//               fixed priority (branch > ixu2 > ixu1 > lsu) and maintains the
//               busy scoreboard used by issue for RAW/WAW stalls.
// Ports       : clk   - clock, rising edge
//               rst_n - synchronous active-low reset
//               wb    - vliw_writeback_if.slave (results, issues, register
//                       file write ports, busy, collision_err)
// Revision    : 1.0 - initial release
// ============================================================================
module vliw_writeback #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    vliw_writeback_if.slave  wb
);
    // Slot index order: 0 lsu, 1 ixu1, 2 ixu2, 3 branch (higher = higher priority)
    localparam int c_NSLOT = 4;

    logic [c_NSLOT-1:0] w_res_valid;
    logic [AW-1:0]      w_res_rd   [c_NSLOT];
    logic [XLEN-1:0]    w_res_data [c_NSLOT];
    logic [c_NSLOT-1:0] w_iss_valid;
    logic [AW-1:0]      w_iss_rd   [c_NSLOT];

    logic [c_NSLOT-1:0] w_keep;
    logic               w_coll;
    logic [NREGS-1:0]   w_set;
    logic [NREGS-1:0]   w_clr;
    logic [NREGS-1:0]   w_busy_next;

    logic [c_NSLOT-1:0] r_wr_en;
    logic [AW-1:0]      r_rd      [c_NSLOT];
    logic [XLEN-1:0]    r_wr_data [c_NSLOT];
    logic [NREGS-1:0]   r_busy;
    logic               r_coll;

    assign w_res_valid   = {wb.branch_res_valid, wb.ixu2_res_valid, wb.ixu1_res_valid, wb.lsu_res_valid};
    assign w_res_rd[0]   = wb.lsu_res_rd;
    assign w_res_rd[1]   = wb.ixu1_res_rd;
    assign w_res_rd[2]   = wb.ixu2_res_rd;
    assign w_res_rd[3]   = wb.branch_res_rd;
    assign w_res_data[0] = wb.lsu_res_data;
    assign w_res_data[1] = wb.ixu1_res_data;
    assign w_res_data[2] = wb.ixu2_res_data;
    assign w_res_data[3] = wb.branch_res_data;
    assign w_iss_valid   = {wb.branch_iss_valid, wb.ixu2_iss_valid, wb.ixu1_iss_valid, wb.lsu_iss_valid};
    assign w_iss_rd[0]   = wb.lsu_iss_rd;
    assign w_iss_rd[1]   = wb.ixu1_iss_rd;
    assign w_iss_rd[2]   = wb.ixu2_iss_rd;
    assign w_iss_rd[3]   = wb.branch_iss_rd;

    // A slot keeps its write only if its rd is nonzero and no higher-index
    // (higher-priority) valid slot targets the same rd.
    always_comb begin
        w_keep = '0;
        w_coll = 1'b0;
        for (int u = 0; u < c_NSLOT; u++) begin
            w_keep[u] = w_res_valid[u] && (w_res_rd[u] != '0);
            for (int v = u + 1; v < c_NSLOT; v++) begin
                if (w_res_valid[u] && w_res_valid[v] &&
                    (w_res_rd[u] != '0) && (w_res_rd[u] == w_res_rd[v])) begin
                    w_keep[u] = 1'b0;
                    w_coll    = 1'b1;
                end
            end
        end
    end

    // Clear comes from the writes committing at this edge (registered ports);
    // set comes from this cycle's issues and is applied after the clear so a
    // re-issue to a just-committing register stays busy.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int u = 0; u < c_NSLOT; u++) begin
            if (r_wr_en[u]) begin
                w_clr[r_rd[u]] = 1'b1;
            end
            if (w_iss_valid[u] && (w_iss_rd[u] != '0)) begin
                w_set[w_iss_rd[u]] = 1'b1;
            end
        end
        w_busy_next    = (r_busy & ~w_clr) | w_set;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en <= '0;
            r_busy  <= '0;
            r_coll  <= 1'b0;
            for (int u = 0; u < c_NSLOT; u++) begin
                r_rd[u]      <= '0;
                r_wr_data[u] <= '0;
            end
        end else if (wb.flush) begin
            r_wr_en <= '0;
            r_busy  <= '0;
        end else begin
            r_wr_en <= w_keep;
            r_busy  <= w_busy_next;
            r_coll  <= r_coll | w_coll;
            // rd/data follow every valid result, dropped or not; only wr_en
            // qualifies the write.
            for (int u = 0; u < c_NSLOT; u++) begin
                if (w_res_valid[u]) begin
                    r_rd[u]      <= w_res_rd[u];
                    r_wr_data[u] <= w_res_data[u];
                end
            end
        end
    end

    assign wb.lsu_wr_en      = r_wr_en[0];
    assign wb.ixu1_wr_en     = r_wr_en[1];
    assign wb.ixu2_wr_en     = r_wr_en[2];
    assign wb.branch_wr_en   = r_wr_en[3];
    assign wb.lsu_rd         = r_rd[0];
    assign wb.ixu1_rd        = r_rd[1];
    assign wb.ixu2_rd        = r_rd[2];
    assign wb.branch_rd      = r_rd[3];
    assign wb.lsu_wr_data    = r_wr_data[0];
    assign wb.ixu1_wr_data   = r_wr_data[1];
    assign wb.ixu2_wr_data   = r_wr_data[2];
    assign wb.branch_wr_data = r_wr_data[3];
    assign wb.busy           = r_busy;
    assign wb.collision_err  = r_coll;

endmodule
`default_nettype wire

// File: tb/tb_vliw_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_vliw_writeback
// Description : Self-checking bench for vliw_writeback. Table of single-cycle
//               result vectors (slot order lsu, ixu1, ixu2, branch) with
//               hand-computed write enables, plus directed sequences for
//               reset, sticky collision flag, flush and the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vliw_writeback;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    vliw_writeback_if #(.NREGS(32), .XLEN(32), .AW(5)) wbif ();

    vliw_writeback #(.NREGS(32), .XLEN(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0]       v;
        logic [3:0][4:0]  rd;
        logic [3:0][31:0] d;
        logic [3:0]       exp_en;
        logic             exp_coll;
    } vec_t;

    localparam int c_NVEC = 8;
    vec_t vecs [c_NVEC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input int u, input logic v, input logic [4:0] rd, input logic [31:0] d);
        case (u)
            0: begin wbif.lsu_res_valid    = v; wbif.lsu_res_rd    = rd; wbif.lsu_res_data    = d; end
            1: begin wbif.ixu1_res_valid   = v; wbif.ixu1_res_rd   = rd; wbif.ixu1_res_data   = d; end
            2: begin wbif.ixu2_res_valid   = v; wbif.ixu2_res_rd   = rd; wbif.ixu2_res_data   = d; end
            default: begin wbif.branch_res_valid = v; wbif.branch_res_rd = rd; wbif.branch_res_data = d; end
        endcase
    endtask

    task automatic drive_iss(input int u, input logic v, input logic [4:0] rd);
        case (u)
            0: begin wbif.lsu_iss_valid    = v; wbif.lsu_iss_rd    = rd; end
            1: begin wbif.ixu1_iss_valid   = v; wbif.ixu1_iss_rd   = rd; end
            2: begin wbif.ixu2_iss_valid   = v; wbif.ixu2_iss_rd   = rd; end
            default: begin wbif.branch_iss_valid = v; wbif.branch_iss_rd = rd; end
        endcase
    endtask

    function automatic logic get_en(input int u);
        case (u)
            0: return wbif.lsu_wr_en;
            1: return wbif.ixu1_wr_en;
            2: return wbif.ixu2_wr_en;
            default: return wbif.branch_wr_en;
        endcase
    endfunction

    function automatic logic [4:0] get_rd(input int u);
        case (u)
            0: return wbif.lsu_rd;
            1: return wbif.ixu1_rd;
            2: return wbif.ixu2_rd;
            default: return wbif.branch_rd;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int u);
        case (u)
            0: return wbif.lsu_wr_data;
            1: return wbif.ixu1_wr_data;
            2: return wbif.ixu2_wr_data;
            default: return wbif.branch_wr_data;
        endcase
    endfunction

    task automatic idle();
        wbif.flush = 1'b0;
        for (int u = 0; u < 4; u++) begin
            drive_res(u, 1'b0, 5'd0, 32'd0);
            drive_iss(u, 1'b0, 5'd0);
        end
    endtask

    task automatic chk_all_en_zero(input string nm);
        for (int u = 0; u < 4; u++) chk($sformatf("%s_en%0d", nm, u), 64'(get_en(u)), 64'd0);
    endtask

    task automatic set_vec(input int i, input logic [3:0] v,
                           input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                           input logic [3:0] en, input logic coll);
        vecs[i].v        = v;
        vecs[i].rd[0]    = r0; vecs[i].rd[1] = r1; vecs[i].rd[2] = r2; vecs[i].rd[3] = r3;
        vecs[i].d[0]     = d0; vecs[i].d[1]  = d1; vecs[i].d[2]  = d2; vecs[i].d[3]  = d3;
        vecs[i].exp_en   = en;
        vecs[i].exp_coll = coll;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        //      idx  valid    rd lsu/ixu1/ixu2/branch   data lsu/ixu1/ixu2/branch                         en       coll
        set_vec(0, 4'b0010, 5'd0,  5'd5,  5'd0,  5'd0,  32'h0,    32'hDEADBEEF, 32'h0,    32'h0,      4'b0010, 1'b0);
        set_vec(1, 4'b0001, 5'd0,  5'd0,  5'd0,  5'd0,  32'h1234, 32'h0,        32'h0,    32'h0,      4'b0000, 1'b0);
        set_vec(2, 4'b0011, 5'd0,  5'd0,  5'd0,  5'd0,  32'hAA,   32'hBB,       32'h0,    32'h0,      4'b0000, 1'b0);
        set_vec(3, 4'b1111, 5'd1,  5'd2,  5'd3,  5'd4,  32'h11,   32'h22,       32'h33,   32'h44,     4'b1111, 1'b0);
        set_vec(4, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,    32'h0,        32'h0,    32'h0,      4'b0000, 1'b0);
        set_vec(5, 4'b1111, 5'd6,  5'd0,  5'd6,  5'd0,  32'hA1,   32'hA2,       32'hA3,   32'hA4,     4'b0100, 1'b1);
        set_vec(6, 4'b1011, 5'd7,  5'd7,  5'd7,  5'd7,  32'h1,    32'h2,        32'h99,   32'h3,      4'b1000, 1'b1);
        set_vec(7, 4'b1111, 5'd30, 5'd31, 5'd31, 5'd30, 32'hC0,   32'hC1,       32'hC2,   32'hC3,     4'b1100, 1'b1);

        // Reset with every slot presenting a result
        idle();
        rst_n = 1'b0;
        for (int u = 0; u < 4; u++) drive_res(u, 1'b1, 5'(u + 10), 32'hF00 + 32'(u));
        step();
        chk_all_en_zero("reset");
        chk("reset_busy", 64'(wbif.busy), 64'd0);
        chk("reset_coll", 64'(wbif.collision_err), 64'd0);
        rst_n = 1'b1;
        idle();
        step();

        // Table-driven single-cycle vectors
        for (int i = 0; i < c_NVEC; i++) begin
            for (int u = 0; u < 4; u++) drive_res(u, vecs[i].v[u], vecs[i].rd[u], vecs[i].d[u]);
            step();
            for (int u = 0; u < 4; u++) begin
                chk($sformatf("vec%0d_en%0d", i, u), 64'(get_en(u)), 64'(vecs[i].exp_en[u]));
                if (vecs[i].v[u]) begin
                    chk($sformatf("vec%0d_rd%0d", i, u), 64'(get_rd(u)), 64'(vecs[i].rd[u]));
                    chk($sformatf("vec%0d_data%0d", i, u), 64'(get_data(u)), 64'(vecs[i].d[u]));
                end
            end
            chk($sformatf("vec%0d_coll", i), 64'(wbif.collision_err), 64'(vecs[i].exp_coll));
            chk($sformatf("vec%0d_busy", i), 64'(wbif.busy), 64'd0);
        end
        idle();

        // collision_err is sticky across idle cycles
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("sticky_coll%0d", k), 64'(wbif.collision_err), 64'd1);
        end
        chk_all_en_zero("idle");

        // Mid-stream reset drops results and clears the sticky flag
        for (int u = 0; u < 4; u++) drive_res(u, 1'b1, 5'(u + 20), 32'hB00 + 32'(u));
        rst_n = 1'b0;
        step();
        chk_all_en_zero("midrst");
        chk("midrst_coll", 64'(wbif.collision_err), 64'd0);
        rst_n = 1'b1;
        idle();
        step();
        chk_all_en_zero("midrst_after");

        // Flushed colliding results neither write nor raise the flag
        wbif.flush = 1'b1;
        drive_res(0, 1'b1, 5'd12, 32'h1);
        drive_res(1, 1'b1, 5'd12, 32'h2);
        step();
        chk_all_en_zero("flushcoll");
        idle();
        step();
        chk("flushcoll_coll", 64'(wbif.collision_err), 64'd0);

        // Scoreboard: issue, result two cycles later, commit clears
        drive_iss(2, 1'b1, 5'd9);
        step();
        idle();
        chk("sb_set", 64'(wbif.busy), 64'h200);
        step();
        chk("sb_hold", 64'(wbif.busy), 64'h200);
        drive_res(2, 1'b1, 5'd9, 32'h55);
        step();
        idle();
        chk("sb_wr_en", 64'(wbif.ixu2_wr_en), 64'd1);
        chk("sb_pre_commit", 64'(wbif.busy), 64'h200);
        step();
        chk("sb_clear", 64'(wbif.busy), 64'h0);

        // Same again, with a new issue to rd 9 on the commit edge
        drive_iss(2, 1'b1, 5'd9);
        step();
        idle();
        step();
        drive_res(2, 1'b1, 5'd9, 32'h66);
        step();
        idle();
        drive_iss(0, 1'b1, 5'd9);
        step();
        idle();
        chk("sb_set_wins", 64'(wbif.busy), 64'h200);
        step();
        chk("sb_set_wins_hold", 64'(wbif.busy), 64'h200);

        // Issue to x0 never marks bit 0
        drive_iss(3, 1'b1, 5'd0);
        step();
        idle();
        chk("sb_x0", 64'(wbif.busy), 64'h200);

        // Flush clears busy even with a concurrent issue
        drive_iss(1, 1'b1, 5'd8);
        step();
        idle();
        chk("fl_pre_busy", 64'(wbif.busy), 64'h300);
        wbif.flush = 1'b1;
        drive_res(1, 1'b1, 5'd8, 32'h77);
        drive_iss(3, 1'b1, 5'd4);
        step();
        idle();
        chk("fl_busy", 64'(wbif.busy), 64'h0);
        chk_all_en_zero("fl");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
